// File: rtl/vol_btn_repeat.sv
// rtl/vol_btn_repeat.sv - vol-/vol+ step, hold-to-repeat and mute-combo event generator
// Optional build macro: VOL_BTN_ACCEL_EN (halves the repeat period after 8 repeat steps)
module vol_btn_repeat #(
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int INITIAL_DELAY  = 12500000,
    parameter int REPEAT_PERIOD  = 2500000,
    parameter int CNT_W          = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_minus,
    input  logic       i_btn_plus,
    input  logic       i_clr,
    output logic       o_step_up,
    output logic       o_step_dn,
    output logic       o_mute,
    output logic [7:0] o_delta,
    output logic       o_mute_flag,
    output logic       o_busy
);

    // Terminal counts: the counter runs 0..TC, so a pulse lands exactly N cycles after the previous one
    localparam logic [CNT_W-1:0] INIT_TC = CNT_W'(INITIAL_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_PERIOD - 1);
`ifdef VOL_BTN_ACCEL_EN
    localparam int               FAST_PERIOD = (REPEAT_PERIOD / 2 < 1) ? 1 : REPEAT_PERIOD / 2;
    localparam logic [CNT_W-1:0] FAST_TC     = CNT_W'(FAST_PERIOD - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD_UP,
        ST_HOLD_DN,
        ST_REP_UP,
        ST_REP_DN,
        ST_WAIT_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             mute_q, mute_d;
    logic [7:0]       delta_q, delta_d;
    logic             flag_q, flag_d;
    logic             busy_q;
`ifdef VOL_BTN_ACCEL_EN
    logic [3:0]       rep_cnt_q, rep_cnt_d;
`endif

    logic             p, m;
    logic             is_up, in_rep, own, other;
    logic [CNT_W-1:0] tc;
    logic [7:0]       delta_base;

    assign p = BTN_ACTIVE_LOW ? ~i_btn_plus  : i_btn_plus;
    assign m = BTN_ACTIVE_LOW ? ~i_btn_minus : i_btn_minus;

    // Next-state decision: FSM transitions, step/mute events, delta and sticky flag
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
        mute_d    = 1'b0;
        is_up     = (state_q == ST_HOLD_UP) || (state_q == ST_REP_UP);
        in_rep    = (state_q == ST_REP_UP)  || (state_q == ST_REP_DN);
        own       = is_up ? p : m;
        other     = is_up ? m : p;
`ifdef VOL_BTN_ACCEL_EN
        rep_cnt_d = rep_cnt_q;
        if (in_rep) begin
            tc = (rep_cnt_q >= 4'd8) ? FAST_TC : REP_TC;
        end else begin
            tc = INIT_TC;
        end
`else
        tc = in_rep ? REP_TC : INIT_TC;
`endif

        case (state_q)
            ST_IDLE: begin
                if (p && m) begin
                    mute_d  = 1'b1;
                    state_d = ST_WAIT_REL;
                end else if (p) begin
                    step_up_d = 1'b1;
                    state_d   = ST_HOLD_UP;
                    cnt_d     = '0;
                end else if (m) begin
                    step_dn_d = 1'b1;
                    state_d   = ST_HOLD_DN;
                    cnt_d     = '0;
                end
            end
            ST_HOLD_UP, ST_HOLD_DN, ST_REP_UP, ST_REP_DN: begin
                // Release wins over a terminal count; a handover to the other
                // button passes through IDLE so the new press is seen fresh.
                if (!own) begin
                    state_d = ST_IDLE;
                end else if (other) begin
                    mute_d  = 1'b1;
                    state_d = ST_WAIT_REL;
                end else if (cnt_q == tc) begin
                    step_up_d = is_up;
                    step_dn_d = ~is_up;
                    cnt_d     = '0;
                    state_d   = is_up ? ST_REP_UP : ST_REP_DN;
`ifdef VOL_BTN_ACCEL_EN
                    if (!in_rep) begin
                        rep_cnt_d = 4'd1;
                    end else if (rep_cnt_q < 4'd8) begin
                        rep_cnt_d = rep_cnt_q + 4'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!p && !m) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef VOL_BTN_ACCEL_EN
        if (state_d != ST_REP_UP && state_d != ST_REP_DN) begin
            rep_cnt_d = 4'd0;
        end
`endif

        // Clear first, then apply this cycle's step with saturation
        delta_base = i_clr ? 8'h00 : delta_q;
        delta_d    = delta_base;
        if (step_up_d && delta_base != 8'h7F) begin
            delta_d = delta_base + 8'h01;
        end else if (step_dn_d && delta_base != 8'h80) begin
            delta_d = delta_base - 8'h01;
        end

        flag_d = mute_d | (flag_q & ~i_clr);
    end

    // State, counter and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            mute_q    <= 1'b0;
            delta_q   <= 8'h00;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef VOL_BTN_ACCEL_EN
            rep_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            mute_q    <= mute_d;
            delta_q   <= delta_d;
            flag_q    <= flag_d;
            busy_q    <= (state_d != ST_IDLE);
`ifdef VOL_BTN_ACCEL_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    assign o_step_up   = step_up_q;
    assign o_step_dn   = step_dn_q;
    assign o_mute      = mute_q;
    assign o_delta     = delta_q;
    assign o_mute_flag = flag_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_vol_btn_repeat.sv
// tb/tb_vol_btn_repeat.sv - scoreboard bench for vol_btn_repeat
module tb_vol_btn_repeat;

    localparam int ID = 20;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_minus;
    logic       btn_plus;
    logic       clr;
    logic       step_up;
    logic       step_dn;
    logic       mute;
    logic [7:0] delta;
    logic       mute_flag;
    logic       busy;

    always #5 clk = ~clk;

    vol_btn_repeat #(
        .BTN_ACTIVE_LOW(1'b1),
        .INITIAL_DELAY (ID),
        .REPEAT_PERIOD (RP),
        .CNT_W         (8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_minus(btn_minus),
        .i_btn_plus (btn_plus),
        .i_clr      (clr),
        .o_step_up  (step_up),
        .o_step_dn  (step_dn),
        .o_mute     (mute),
        .o_delta    (delta),
        .o_mute_flag(mute_flag),
        .o_busy     (busy)
    );

    typedef struct {
        int t;
        int k;
    } ev_t;

    typedef struct {
        int t;
        int d;
        bit f;
        bit b;
    } st_t;

    ev_t evq[$];
    st_t stq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = -1;
    bit  final_req = 1'b0;

    // stimulus arrays of the phase being built (1 = pressed)
    bit  p_a[1024];
    bit  m_a[1024];
    bit  c_a[1024];
    bit  r_a[1024];
    int  nt;

    // reference model: 0 free, 1 holding plus, 2 holding minus, 3 combo latched
    int  mdl_mode = 0;
    int  mdl_d = 0;
    bit  mdl_f = 1'b0;
    int  evk[1025];
    bit  bz[1025];

    function automatic void add_hold(input int s, input int len, input int k);
        evk[s + 1] = k;
        for (int off = ID; off < len; off += RP) begin
            evk[s + off + 1] = k;
        end
    endfunction

    task automatic seg(input bit r, input bit p, input bit m, input bit c, input int n);
        for (int i = 0; i < n; i++) begin
            r_a[nt] = r;
            p_a[nt] = p;
            m_a[nt] = m;
            c_a[nt] = c;
            nt++;
        end
    endtask

    task automatic drive(input bit r, input bit p, input bit m, input bit c);
        @(posedge clk);
        #1;
        cyc       = cyc + 1;
        rst       = r;
        btn_plus  = ~p;
        btn_minus = ~m;
        clr       = c;
    endtask

    task automatic run_phase(input int len);
        int  base;
        int  t;
        int  s;
        int  sl;
        int  k;
        bit  pp;
        bit  mm;
        st_t sv;
        ev_t ev;
        base = cyc + 1;
        for (int i = 0; i <= len; i++) begin
            evk[i] = 0;
            bz[i]  = 1'b0;
        end
        t = 0;
        while (t < len) begin
            if (r_a[t]) begin
                mdl_mode = 0;
                t++;
            end else begin
                s  = t;
                pp = p_a[t];
                mm = m_a[t];
                while (t < len && !r_a[t] && p_a[t] == pp && m_a[t] == mm) t++;
                sl = t - s;
                if (pp && mm) begin
                    if (mdl_mode != 3) evk[s + 1] = 3;
                    mdl_mode = 3;
                    for (int u = s; u < s + sl; u++) bz[u + 1] = 1'b1;
                end else if (!pp && !mm) begin
                    mdl_mode = 0;
                end else begin
                    k = pp ? 1 : 2;
                    if (mdl_mode == 3) begin
                        for (int u = s; u < s + sl; u++) bz[u + 1] = 1'b1;
                    end else if (mdl_mode == 0) begin
                        add_hold(s, sl, k);
                        mdl_mode = k;
                        for (int u = s; u < s + sl; u++) bz[u + 1] = 1'b1;
                    end else if (sl > 1) begin
                        add_hold(s + 1, sl - 1, k);
                        mdl_mode = k;
                        for (int u = s + 1; u < s + sl; u++) bz[u + 1] = 1'b1;
                    end else begin
                        mdl_mode = 0;
                    end
                end
            end
        end
        for (t = 1; t <= len; t++) begin
            if (r_a[t - 1]) begin
                mdl_d = 0;
                mdl_f = 1'b0;
            end else begin
                if (c_a[t - 1]) mdl_d = 0;
                if (evk[t] == 1 && mdl_d < 127) mdl_d = mdl_d + 1;
                if (evk[t] == 2 && mdl_d > -128) mdl_d = mdl_d - 1;
                mdl_f = (evk[t] == 3) || (mdl_f && !c_a[t - 1]);
            end
            sv.t = base + t;
            sv.d = mdl_d;
            sv.f = mdl_f;
            sv.b = bz[t];
            stq.push_back(sv);
            if (evk[t] != 0) begin
                ev.t = base + t;
                ev.k = evk[t];
                evq.push_back(ev);
            end
        end
        for (t = 0; t < len; t++) drive(r_a[t], p_a[t], m_a[t], c_a[t]);
    endtask

    task automatic random_phase();
        logic [1:0] pat;
        int         n;
        nt = 0;
        n  = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) begin
            pat = 2'($urandom_range(0, 3));
            seg(1'b0, pat[0], pat[1], 1'b0, $urandom_range(1, 40));
        end
        for (int i = 0; i < nt; i++) begin
            c_a[i] = ($urandom_range(0, 15) == 0);
            r_a[i] = ($urandom_range(0, 199) == 0);
        end
        seg(1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_phase(nt);
    endtask

    // monitor: pops expected pulses and per-cycle status whenever the DUT presents them
    always @(negedge clk) begin : mon
        int kd;
        bit multi;
        kd    = step_up ? 1 : step_dn ? 2 : mute ? 3 : 0;
        multi = (step_up & step_dn) | (step_up & mute) | (step_dn & mute);
        while (evq.size() > 0 && evq[0].t < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_pulse t=%0d got none want kind=%0d", evq[0].t, evq[0].k);
            void'(evq.pop_front());
        end
        if (kd != 0 || (evq.size() > 0 && evq[0].t == cyc)) begin
            total++;
            if (evq.size() == 0 || evq[0].t != cyc) begin
                bad++;
                $display("FAIL unexpected_pulse t=%0d got kind=%0d want none", cyc, kd);
            end else begin
                if (kd != evq[0].k || multi) begin
                    bad++;
                    $display("FAIL pulse t=%0d got kind=%0d multi=%0d want kind=%0d",
                             cyc, kd, multi, evq[0].k);
                end
                void'(evq.pop_front());
            end
        end
        while (stq.size() > 0 && stq[0].t < cyc) void'(stq.pop_front());
        if (stq.size() > 0 && stq[0].t == cyc) begin
            total++;
            if (int'($signed(delta)) != stq[0].d || mute_flag != stq[0].f || busy != stq[0].b) begin
                bad++;
                $display("FAIL status t=%0d got delta=%0d flag=%0d busy=%0d want delta=%0d flag=%0d busy=%0d",
                         cyc, $signed(delta), mute_flag, busy, stq[0].d, stq[0].f, stq[0].b);
            end
            void'(stq.pop_front());
        end
        if (final_req) begin
            total++;
            if (evq.size() != 0 || stq.size() != 0) begin
                bad++;
                $display("FAIL drain got pending_events=%0d pending_status=%0d want 0 0",
                         evq.size(), stq.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        rst       = 1'b1;
        btn_plus  = 1'b1;
        btn_minus = 1'b1;
        clr       = 1'b0;

        // reset held with both pressed, then the combo fires once reset lifts
        nt = 0;
        seg(1'b1, 1'b1, 1'b1, 1'b0, 3);
        seg(1'b0, 1'b1, 1'b1, 1'b0, 4);
        seg(1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_phase(nt);

        // single short press
        nt = 0;
        seg(1'b0, 1'b1, 1'b0, 1'b0, 10);
        seg(1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_phase(nt);

        // long hold with auto-repeat
        nt = 0;
        seg(1'b0, 1'b0, 1'b1, 1'b0, 50);
        seg(1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_phase(nt);

        // combo during a hold, then release plus alone
        nt = 0;
        seg(1'b0, 1'b1, 1'b0, 1'b0, 10);
        seg(1'b0, 1'b1, 1'b1, 1'b0, 10);
        seg(1'b0, 1'b0, 1'b1, 1'b0, 5);
        seg(1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_phase(nt);

        // saturation from a cleared delta, then clear coincident with a step_dn
        nt = 0;
        seg(1'b0, 1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 130; i++) begin
            seg(1'b0, 1'b1, 1'b0, 1'b0, 2);
            seg(1'b0, 1'b0, 1'b0, 1'b0, 2);
        end
        seg(1'b0, 1'b0, 1'b1, 1'b1, 1);
        seg(1'b0, 1'b0, 1'b1, 1'b0, 3);
        seg(1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_phase(nt);

        // handover plus -> minus in one cycle
        nt = 0;
        seg(1'b0, 1'b1, 1'b0, 1'b0, 8);
        seg(1'b0, 1'b0, 1'b1, 1'b0, 10);
        seg(1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_phase(nt);

        // reset in the middle of a hold
        nt = 0;
        seg(1'b0, 1'b1, 1'b0, 1'b0, 15);
        seg(1'b1, 1'b1, 1'b0, 1'b0, 2);
        seg(1'b0, 1'b1, 1'b0, 1'b0, 10);
        seg(1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_phase(nt);

        for (int ph = 0; ph < 20; ph++) random_phase();

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        final_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_end got no summary want summary");
        $fatal(1);
    end

endmodule
